gcd_share_arb: RTL and testbench
================================

# gcd_share_arb

Round-robin arbiter and sequencer that shares one `gcd` unit among `num_req_p` requesters. Requesters present operand pairs on valid/ready ports. The arbiter grants one requester, issues its operands to the `gcd` unit and captures the result. It then returns the result on a single tagged response port with valid/yumi handshake. It sits between the trace-driven or array-side clients and the single `gcd` datapath instance. It allows at most one operation in flight.

## Interface
- `num_req_p`, default 4: number of requesters; legal range 2..16.
- `width_p`, default 32: operand and result width in bits.
- `id_w_lp`, derived: `$clog2(num_req_p)`; tag width.
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `reset_n_i`  in  1  synchronous, active-low reset.
- `req_v_i`  in  num_req_p  per-requester operand valid.
- `req_a_i`  in  num_req_p*width_p  packed operand A; requester k uses bits [k*width_p +: width_p].
- `req_b_i`  in  num_req_p*width_p  packed operand B, same packing as `req_a_i`.
- `req_ready_o`  out  num_req_p  one-hot grant/accept; a transfer occurs when `req_v_i[k] & req_ready_o[k]`.
- `gcd_v_o`  out  1  operands valid to `gcd`.
- `gcd_a_o`, `gcd_b_o`  out  width_p each  latched operands.
- `gcd_ready_i`  in  1  `gcd` input ready.
- `gcd_v_i`  in  1  `gcd` result valid.
- `gcd_y_i`  in  width_p  `gcd` result.
- `gcd_yumi_o`  out  1  result consumed.
- `res_v_o`  out  1  response valid.
- `res_id_o`  out  id_w_lp  index of the owning requester.
- `res_data_o`  out  width_p  GCD result.
- `res_yumi_i`  in  1  response consumed; legal only while `res_v_o` is high.
- `ops_done_o`  out  16  completed-operation counter; wraps.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RETURN.
- IDLE:
  - Search for a requester starting at `last_grant+1` mod `num_req_p` and wrapping.
  - The first k with `req_v_i[k]` is granted.
  - `req_ready_o[k]=1` combinationally in that same cycle.
  - On that edge, latch A, B and the owner id k, set `last_grant<=k`, and go to ISSUE.
  - With no valid request, stay in IDLE; `req_ready_o` stays all zero.
- ISSUE: `gcd_v_o=1` with the latched operands. When `gcd_ready_i=1`, the transfer occurs and the FSM goes to WAIT.
- WAIT:
  - `gcd_yumi_o = gcd_v_i`; the result is taken in the same cycle it appears.
  - Latch `gcd_y_i` into `res_data_o` and go to RETURN.
- RETURN:
  - `res_v_o=1`; `res_id_o`=owner, `res_data_o` held stable.
  - On `res_yumi_i`: `ops_done_o` increments by 1 (0xFFFF wraps to 0) and the FSM goes to IDLE.
- `req_ready_o` is zero in every state except IDLE. Requests arriving while busy are held by their sources and re-arbitrated in IDLE.
- `gcd_v_i` outside WAIT is never acknowledged: `gcd_yumi_o=0`.
- Operands of 0 are passed through unchanged. Result semantics belong to `gcd`; the arbiter never inspects data.

## Timing
- Reset (`reset_n_i=0` at a rising edge):
  - State=IDLE, `last_grant=num_req_p-1` so requester 0 has first priority.
  - Outputs `req_ready_o=0`, `gcd_v_o=0`, `gcd_yumi_o=0`, `res_v_o=0`, `res_id_o=0`, `res_data_o=0`, `gcd_a_o/gcd_b_o=0`, `ops_done_o=0`.
- Reset mid-operation abandons the in-flight op with no response. `gcd` shares the same reset and must be reset together.
- Grant to issue: `gcd_v_o` rises exactly 1 cycle after the accept edge.
- Issue to result: `gcd` latency L cycles. The result is captured on the cycle `gcd_v_i` is high, and `res_v_o` rises the next cycle.
- Minimum issue interval: 4 cycles plus L per operation. A new grant can occur the cycle after `res_yumi_i`, not the same cycle.
- Simultaneous requests resolve purely by the rotating pointer. A continuously requesting client waits at most `num_req_p-1` other operations.
- `gcd_v_o` and `res_v_o` are registered-state driven and must not drop before their handshake completes.

## Test plan
- Single request: requester 0 sends A=48, B=18 -> `req_ready_o=0001` in the same cycle; later `res_v_o=1`, `res_id_o=0`, `res_data_o=6`, `ops_done_o=1` after yumi.
- All four request simultaneously after reset, with pairs (48,18), (35,21), (100,75), (17,5):
  - Grants in order 0,1,2,3.
  - Responses (id,data) = (0,6), (1,7), (2,25), (3,1), in that order.
- Rotation fairness: requesters 1 and 3 request continuously for 8 ops -> grants alternate 1,3,1,3,…; requester 1 is never granted twice in a row.
- Backpressure:
  - Hold `gcd_ready_i=0` for 10 cycles in ISSUE -> `gcd_v_o` and operands stay stable.
  - Hold `res_yumi_i=0` for 10 cycles -> `res_v_o`, `res_id_o` and `res_data_o` stay stable, and `req_ready_o` stays 0.
- Reset mid-op: assert `reset_n_i=0` in WAIT -> the next cycle has all outputs 0 and no response is emitted. A new request to requester 2 after reset is granted before requester 3 when both request (priority restarts at 0).
- Counter wrap: preload by running 65536 ops, or force the counter via the bench -> `ops_done_o` goes from 0xFFFF to 0x0000.

Source files
------------

// File: rtl/gcd_share_arb.sv
// Round-robin arbiter sharing one gcd unit among num_req_p requesters.
// One operation in flight; results return on a tagged valid/yumi port.
module gcd_share_arb #(
   parameter int num_req_p = 4,
   parameter int width_p   = 32,
   localparam int id_w_lp  = $clog2(num_req_p)
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [num_req_p-1:0]           req_v_i,
   input  logic [num_req_p*width_p-1:0]   req_a_i,
   input  logic [num_req_p*width_p-1:0]   req_b_i,
   output logic [num_req_p-1:0]           req_ready_o,
   output logic                           gcd_v_o,
   output logic [width_p-1:0]             gcd_a_o,
   output logic [width_p-1:0]             gcd_b_o,
   input  logic                           gcd_ready_i,
   input  logic                           gcd_v_i,
   input  logic [width_p-1:0]             gcd_y_i,
   output logic                           gcd_yumi_o,
   output logic                           res_v_o,
   output logic [id_w_lp-1:0]             res_id_o,
   output logic [width_p-1:0]             res_data_o,
   input  logic                           res_yumi_i,
   output logic [15:0]                    ops_done_o
);

   localparam logic [1:0] state_idle   = 2'd0;
   localparam logic [1:0] state_issue  = 2'd1;
   localparam logic [1:0] state_wait   = 2'd2;
   localparam logic [1:0] state_return = 2'd3;

   logic [1:0]          state_r;
   logic [id_w_lp-1:0]  last_grant_r;
   logic [id_w_lp-1:0]  owner_r;
   logic [width_p-1:0]  a_r;
   logic [width_p-1:0]  b_r;
   logic [width_p-1:0]  res_r;
   logic [15:0]         ops_done_r;

   logic                grant_found;
   logic [id_w_lp-1:0]  grant_id;
   int unsigned         cand;

   // Rotating search starting just past the last grant; first valid wins.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = 0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         cand = 32'(last_grant_r) + 32'd1 + i;
         if (cand >= 32'(num_req_p))
            cand = cand - 32'(num_req_p);
         if (!grant_found && req_v_i[cand[id_w_lp-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = cand[id_w_lp-1:0];
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (state_r == state_idle && grant_found)
         req_ready_o[grant_id] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r      <= state_idle;
         last_grant_r <= id_w_lp'(num_req_p - 1);
         owner_r      <= '0;
         a_r          <= '0;
         b_r          <= '0;
         res_r        <= '0;
         ops_done_r   <= '0;
      end else begin
         case (state_r)
            state_idle: begin
               if (grant_found) begin
                  a_r          <= req_a_i[grant_id*width_p +: width_p];
                  b_r          <= req_b_i[grant_id*width_p +: width_p];
                  owner_r      <= grant_id;
                  last_grant_r <= grant_id;
                  state_r      <= state_issue;
               end
            end
            state_issue: begin
               if (gcd_ready_i)
                  state_r <= state_wait;
            end
            state_wait: begin
               if (gcd_v_i) begin
                  res_r   <= gcd_y_i;
                  state_r <= state_return;
               end
            end
            default: begin
               if (res_yumi_i) begin
                  ops_done_r <= ops_done_r + 16'd1;
                  state_r    <= state_idle;
               end
            end
         endcase
      end
   end

   assign gcd_v_o    = (state_r == state_issue);
   assign gcd_a_o    = a_r;
   assign gcd_b_o    = b_r;
   assign gcd_yumi_o = (state_r == state_wait) && gcd_v_i;
   assign res_v_o    = (state_r == state_return);
   assign res_id_o   = owner_r;
   assign res_data_o = res_r;
   assign ops_done_o = ops_done_r;

endmodule

// File: tb/tb_gcd_share_arb.sv
// Bench for gcd_share_arb: behavioural gcd unit plus a response scoreboard.
module tb_gcd_share_arb;

   localparam int n_lp = 4;
   localparam int w_lp = 32;
   localparam int lat  = 2;

   logic              clk_i = 1'b0;
   logic              reset_n_i;
   logic [n_lp-1:0]   req_v_i;
   logic [n_lp*w_lp-1:0] req_a_i;
   logic [n_lp*w_lp-1:0] req_b_i;
   logic [n_lp-1:0]   req_ready_o;
   logic              gcd_v_o;
   logic [w_lp-1:0]   gcd_a_o;
   logic [w_lp-1:0]   gcd_b_o;
   logic              gcd_ready_i;
   logic              gcd_v_i;
   logic [w_lp-1:0]   gcd_y_i;
   logic              gcd_yumi_o;
   logic              res_v_o;
   logic [1:0]        res_id_o;
   logic [w_lp-1:0]   res_data_o;
   logic              res_yumi_i;
   logic [15:0]       ops_done_o;

   gcd_share_arb #(.num_req_p(n_lp), .width_p(w_lp)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .req_v_i(req_v_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
      .req_ready_o(req_ready_o),
      .gcd_v_o(gcd_v_o), .gcd_a_o(gcd_a_o), .gcd_b_o(gcd_b_o),
      .gcd_ready_i(gcd_ready_i), .gcd_v_i(gcd_v_i), .gcd_y_i(gcd_y_i),
      .gcd_yumi_o(gcd_yumi_o),
      .res_v_o(res_v_o), .res_id_o(res_id_o), .res_data_o(res_data_o),
      .res_yumi_i(res_yumi_i), .ops_done_o(ops_done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          id;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          glog[$];
   logic [31:0] op_a [n_lp];
   logic [31:0] op_b [n_lp];
   logic [n_lp-1:0] drop;
   logic [n_lp-1:0] cont;
   logic        yumi_en;
   logic [15:0] exp_ops;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y, t;
      x = a; y = b;
      while (y != 0) begin
         t = y; y = x % y; x = t;
      end
      return x;
   endfunction

   // Behavioural gcd unit: fixed latency, holds result until acknowledged.
   int          mstate;
   int          mcnt;
   logic [31:0] ma, mb;
   initial begin
      mstate = 0; mcnt = 0; gcd_v_i = 1'b0; gcd_y_i = '0; ma = '0; mb = '0;
      forever begin
         @(negedge clk_i); #2;
         if (!reset_n_i) begin
            mstate = 0; gcd_v_i = 1'b0;
         end else begin
            case (mstate)
               0: if (gcd_v_o && gcd_ready_i) begin
                     ma = gcd_a_o; mb = gcd_b_o; mcnt = lat; mstate = 1;
                  end
               1: begin
                     mcnt--;
                     if (mcnt == 0) begin
                        gcd_v_i = 1'b1; gcd_y_i = gcd_ref(ma, mb); mstate = 2;
                     end
                  end
               3: begin gcd_v_i = 1'b0; mstate = 0; end
               default: ;
            endcase
            if (mstate == 2) begin
               #1;
               if (gcd_yumi_o) mstate = 3;
            end
         end
      end
   end

   task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
      op_a[k] = a; op_b[k] = b;
      req_a_i[k*w_lp +: w_lp] = a;
      req_b_i[k*w_lp +: w_lp] = b;
      req_v_i[k] = 1'b1;
   endtask

   // One cycle: record accepts, consume/score a response, advance to next negedge.
   task automatic step();
      exp_t e;
      #1;
      for (int k = 0; k < n_lp; k++) begin
         if (req_v_i[k] && req_ready_o[k]) begin
            e.id = k; e.data = gcd_ref(op_a[k], op_b[k]);
            sb.push_back(e); glog.push_back(k); drop[k] = 1'b1;
         end
      end
      if (res_v_o && yumi_en) begin
         total_cnt++;
         if (sb.size() == 0) begin
            $display("FAIL resp_unexpected: got id=%0d data=%0d, required none", res_id_o, res_data_o);
         end else begin
            e = sb.pop_front();
            if (res_id_o !== 2'(e.id) || res_data_o !== e.data)
               $display("FAIL resp: got id=%0d data=%0d, required id=%0d data=%0d",
                        res_id_o, res_data_o, e.id, e.data);
            else pass_cnt++;
         end
         exp_ops++;
         res_yumi_i = 1'b1;
      end
      @(posedge clk_i); @(negedge clk_i);
      res_yumi_i = 1'b0;
      for (int k = 0; k < n_lp; k++)
         if (drop[k] && !cont[k]) req_v_i[k] = 1'b0;
      drop = '0;
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while ((sb.size() != 0 || req_v_i != '0) && n < budget) begin
         step(); n++;
      end
      total_cnt++;
      if (n >= budget) $display("FAIL %s_timeout: got %0d pending, required 0", name, sb.size());
      else pass_cnt++;
   endtask

   task automatic apply_reset();
      reset_n_i = 1'b0; req_v_i = '0; cont = '0; drop = '0; res_yumi_i = 1'b0;
      @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
      reset_n_i = 1'b1;
      sb.delete(); glog.delete(); exp_ops = '0;
   endtask

   task automatic test_reset();
      apply_reset();
      total_cnt++;
      if ({req_ready_o, gcd_v_o, gcd_yumi_o, res_v_o} !== '0)
         $display("FAIL reset_ctrl: got %b, required 0", {req_ready_o, gcd_v_o, gcd_yumi_o, res_v_o});
      else pass_cnt++;
      total_cnt++;
      if ({res_id_o, res_data_o, gcd_a_o, gcd_b_o, ops_done_o} !== '0)
         $display("FAIL reset_data: got id=%0d data=%0d a=%0d b=%0d ops=%0d, required 0",
                  res_id_o, res_data_o, gcd_a_o, gcd_b_o, ops_done_o);
      else pass_cnt++;
   endtask

   task automatic test_single();
      set_req(0, 32'd48, 32'd18);
      #1;
      total_cnt++;
      if (req_ready_o !== 4'b0001) $display("FAIL single_ready: got %b, required 0001", req_ready_o);
      else pass_cnt++;
      step();
      total_cnt++;
      if (gcd_v_o !== 1'b1 || gcd_a_o !== 32'd48 || gcd_b_o !== 32'd18)
         $display("FAIL single_issue: got v=%b a=%0d b=%0d, required v=1 a=48 b=18", gcd_v_o, gcd_a_o, gcd_b_o);
      else pass_cnt++;
      drain(40, "single");
      total_cnt++;
      if (ops_done_o !== 16'd1) $display("FAIL single_ops: got %0d, required 1", ops_done_o);
      else pass_cnt++;
   endtask

   task automatic test_all_four();
      logic [31:0] pa [4] = '{48, 35, 100, 17};
      logic [31:0] pb [4] = '{18, 21, 75, 5};
      apply_reset();
      for (int k = 0; k < 4; k++) set_req(k, pa[k], pb[k]);
      drain(100, "all4");
      total_cnt++;
      if (glog.size() != 4 || glog[0] != 0 || glog[1] != 1 || glog[2] != 2 || glog[3] != 3)
         $display("FAIL all4_order: got %p, required 0,1,2,3", glog);
      else pass_cnt++;
      total_cnt++;
      if (ops_done_o !== exp_ops || ops_done_o !== 16'd4)
         $display("FAIL all4_ops: got %0d, required 4", ops_done_o);
      else pass_cnt++;
   endtask

   task automatic test_rotation();
      int n = 0;
      bit ok = 1'b1;
      apply_reset();
      cont = 4'b1010;
      set_req(1, 32'd12, 32'd8);
      set_req(3, 32'd81, 32'd27);
      while (glog.size() < 8 && n < 200) begin step(); n++; end
      cont = '0; req_v_i = '0;
      drain(40, "rot");
      for (int i = 0; i < 8; i++)
         if (i >= glog.size() || glog[i] != ((i % 2 == 0) ? 1 : 3)) ok = 1'b0;
      total_cnt++;
      if (!ok) $display("FAIL rot_order: got %p, required 1,3 alternating x8", glog);
      else pass_cnt++;
      ok = 1'b1;
      for (int i = 1; i < glog.size(); i++)
         if (glog[i] == 1 && glog[i-1] == 1) ok = 1'b0;
      total_cnt++;
      if (!ok) $display("FAIL rot_repeat: got %p, required no back-to-back 1", glog);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int n = 0;
      gcd_ready_i = 1'b0;
      set_req(2, 32'd0, 32'd9);
      step();
      for (int i = 0; i < 10; i++) begin
         total_cnt++;
         if (gcd_v_o !== 1'b1 || gcd_a_o !== 32'd0 || gcd_b_o !== 32'd9)
            $display("FAIL bp_issue: got v=%b a=%0d b=%0d, required v=1 a=0 b=9", gcd_v_o, gcd_a_o, gcd_b_o);
         else pass_cnt++;
         step();
      end
      gcd_ready_i = 1'b1;
      yumi_en = 1'b0;
      while (!res_v_o && n < 20) begin step(); n++; end
      set_req(0, 32'd14, 32'd21);
      for (int i = 0; i < 10; i++) begin
         total_cnt++;
         if (res_v_o !== 1'b1 || res_id_o !== 2'd2 || res_data_o !== 32'd9 || req_ready_o !== 4'b0000)
            $display("FAIL bp_hold: got v=%b id=%0d data=%0d rdy=%b, required v=1 id=2 data=9 rdy=0000",
                     res_v_o, res_id_o, res_data_o, req_ready_o);
         else pass_cnt++;
         step();
      end
      yumi_en = 1'b1;
      drain(60, "bp");
   endtask

   task automatic test_reset_midop();
      set_req(1, 32'd30, 32'd45);
      step();
      step();
      sb.delete(); glog.delete();
      reset_n_i = 1'b0; req_v_i = '0;
      @(posedge clk_i); @(negedge clk_i);
      reset_n_i = 1'b1; exp_ops = '0;
      #1;
      total_cnt++;
      if ({req_ready_o, gcd_v_o, gcd_yumi_o, res_v_o, res_id_o, res_data_o, gcd_a_o, gcd_b_o, ops_done_o} !== '0)
         $display("FAIL midrst_zero: got v=%b res_v=%b data=%0d ops=%0d, required all 0",
                  gcd_v_o, res_v_o, res_data_o, ops_done_o);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         total_cnt++;
         if (res_v_o !== 1'b0) $display("FAIL midrst_noresp: got res_v=%b, required 0", res_v_o);
         else pass_cnt++;
         step();
      end
      set_req(2, 32'd20, 32'd8);
      set_req(3, 32'd9, 32'd6);
      drain(60, "midrst");
      total_cnt++;
      if (glog.size() != 2 || glog[0] != 2 || glog[1] != 3)
         $display("FAIL midrst_prio: got %p, required 2,3", glog);
      else pass_cnt++;
   endtask

   task automatic test_counter_wrap();
      force dut.ops_done_r = 16'hFFFF;
      @(posedge clk_i); @(negedge clk_i);
      release dut.ops_done_r;
      #1;
      total_cnt++;
      if (ops_done_o !== 16'hFFFF) $display("FAIL wrap_pre: got %h, required ffff", ops_done_o);
      else pass_cnt++;
      exp_ops = 16'hFFFF;
      set_req(1, 32'd11, 32'd22);
      drain(40, "wrap");
      total_cnt++;
      if (ops_done_o !== 16'h0000 || exp_ops !== 16'h0000)
         $display("FAIL wrap: got %h, required 0000", ops_done_o);
      else pass_cnt++;
   endtask

   initial begin
      reset_n_i = 1'b0; req_v_i = '0; req_a_i = '0; req_b_i = '0;
      gcd_ready_i = 1'b1; res_yumi_i = 1'b0; yumi_en = 1'b1;
      drop = '0; cont = '0; exp_ops = '0;
      for (int k = 0; k < n_lp; k++) begin op_a[k] = '0; op_b[k] = '0; end
      test_reset();
      test_single();
      test_all_four();
      test_rotation();
      test_backpressure();
      test_reset_midop();
      test_counter_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
